// File: rtl/assoc_set.sv
// N-way set-associative cache set with true-LRU replacement and a registered
// request/ack handshake: one request accepted in IDLE, one ack pulse in RESP.
module assoc_set #(
   parameter int WAYS   = 2,
   parameter int WORDS  = 4,
   parameter int DATA_W = 16,
   parameter int TAG_W  = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       cmp,
   input  logic                       write,
   input  logic [$clog2(WORDS)-1:0]   word,
   input  logic [TAG_W-1:0]           tag,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       valid_in,
   output logic                       hit,
   output logic                       dirty,
   output logic [TAG_W-1:0]           tag_out,
   output logic [DATA_W-1:0]          data_out,
   output logic                       valid,
   output logic                       ack,
   output logic                       state_o
);

   localparam int WAY_W = $clog2(WAYS);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

   // Handshake: enable is sampled only in IDLE; the edge that accepts it
   // performs the operation and registers all outputs, and ack is high for
   // the single RESP cycle that follows. Outputs hold until the next request.
   state_e state_q, state_d;

   logic [DATA_W-1:0] data_q [WAYS][WORDS];
   logic [TAG_W-1:0]  tag_q  [WAYS];
   logic [WAYS-1:0]   valid_q, dirty_q;
   logic [WAY_W-1:0]  age_q  [WAYS];

   logic              hit_q, hit_d;
   logic              dirty_out_q, dirty_out_d;
   logic              valid_out_q, valid_out_d;
   logic [TAG_W-1:0]  tag_out_q, tag_out_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;

   logic [WAYS-1:0]   match;
   logic [WAY_W-1:0]  hit_way, victim, sel;
   logic              hit_c, go, fill, cwr, upd_lru;

   // Lowest index wins both for duplicate tag matches and for invalid ways.
   always_comb begin
      match   = '0;
      hit_way = '0;
      victim  = '0;
      for (int i = 0; i < WAYS; i++)
         match[i] = valid_q[i] && (tag_q[i] == tag);
      for (int i = WAYS - 1; i >= 0; i--)
         if (match[i]) hit_way = WAY_W'(i);
      for (int i = 0; i < WAYS; i++)
         if (age_q[i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
      for (int i = WAYS - 1; i >= 0; i--)
         if (!valid_q[i]) victim = WAY_W'(i);
   end

   assign hit_c   = |match;
   assign go      = (state_q == IDLE) && enable;
   assign fill    = !cmp && write;
   assign cwr     = cmp && write && hit_c;
   assign upd_lru = (cmp && hit_c) || fill;
   assign sel     = (cmp && hit_c) ? hit_way : victim;

   always_comb begin
      state_d     = state_q;
      hit_d       = hit_q;
      dirty_out_d = dirty_out_q;
      valid_out_d = valid_out_q;
      tag_out_d   = tag_out_q;
      data_out_d  = data_out_q;
      case (state_q)
         IDLE: if (enable) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (go) begin
         hit_d       = cmp && hit_c;
         data_out_d  = (fill || cwr) ? data_in : data_q[sel][word];
         tag_out_d   = fill ? tag : tag_q[sel];
         valid_out_d = fill ? valid_in : valid_q[sel];
         dirty_out_d = fill ? 1'b0 : (cwr ? 1'b1 : dirty_q[sel]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         hit_q       <= 1'b0;
         dirty_out_q <= 1'b0;
         valid_out_q <= 1'b0;
         tag_out_q   <= '0;
         data_out_q  <= '0;
         for (int i = 0; i < WAYS; i++) age_q[i] <= WAY_W'(i);
      end else begin
         state_q     <= state_d;
         hit_q       <= hit_d;
         dirty_out_q <= dirty_out_d;
         valid_out_q <= valid_out_d;
         tag_out_q   <= tag_out_d;
         data_out_q  <= data_out_d;
         if (go && fill) begin
            valid_q[sel] <= valid_in;
            dirty_q[sel] <= 1'b0;
         end
         if (go && cwr) dirty_q[sel] <= 1'b1;
         // Accessed way becomes youngest; only younger ways age by one.
         if (go && upd_lru) begin
            for (int i = 0; i < WAYS; i++) begin
               if (WAY_W'(i) == sel)
                  age_q[i] <= '0;
               else if (age_q[i] < age_q[sel])
                  age_q[i] <= age_q[i] + 1'b1;
            end
         end
      end
   end

   // Tag and data storage carry no reset.
   always_ff @(posedge clk) begin
      if (go && (fill || cwr)) data_q[sel][word] <= data_in;
      if (go && fill) tag_q[sel] <= tag;
   end

   assign hit      = hit_q;
   assign dirty    = dirty_out_q;
   assign valid    = valid_out_q;
   assign tag_out  = tag_out_q;
   assign data_out = data_out_q;
   assign ack      = (state_q == RESP);
   assign state_o  = (state_q == RESP);

endmodule

// File: tb/tb_assoc_set.sv
// Bench for assoc_set: directed scenarios with literal expectations, then
// random traffic checked every cycle against an LRU-list reference model.
module tb_assoc_set;

   localparam int WAYS   = 2;
   localparam int WORDS  = 4;
   localparam int DATA_W = 16;
   localparam int TAG_W  = 5;
   localparam int WB     = $clog2(WORDS);
   localparam int EW     = 5 + TAG_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0, cmp = 1'b0, write = 1'b0, valid_in = 1'b0;
   logic [WB-1:0]     word = '0;
   logic [TAG_W-1:0]  tag = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              hit, dirty, valid, ack, dbg_state;
   logic [TAG_W-1:0]  tag_out;
   logic [DATA_W-1:0] data_out;

   assoc_set #(.WAYS(WAYS), .WORDS(WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cmp(cmp), .write(write),
      .word(word), .tag(tag), .data_in(data_in), .valid_in(valid_in),
      .hit(hit), .dirty(dirty), .tag_out(tag_out), .data_out(data_out),
      .valid(valid), .ack(ack), .state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int ack_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: lru_q lists ways from most to least recently used.
   logic [DATA_W-1:0] m_data [WAYS][WORDS];
   bit                m_dk   [WAYS][WORDS];
   logic [TAG_W-1:0]  m_tag  [WAYS];
   bit                m_tk   [WAYS];
   bit                m_valid[WAYS];
   bit                m_dirty[WAYS];
   int                lru_q[$];

   // Expected entry: {data_known, tag_known, hit, dirty, valid, tag, data}.
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] cur;
   bit            ack_due = 0;
   bit            chk_en  = 0;

   function automatic logic [EW-1:0] reset_view();
      return {2'b11, {(EW-2){1'b0}}};
   endfunction

   task automatic model_reset();
      lru_q.delete();
      for (int i = 0; i < WAYS; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
         lru_q.push_back(i);
      end
      exp_q.delete();
      ack_due = 0;
      cur = reset_view();
   endtask

   task automatic touch(input int way);
      for (int i = 0; i < lru_q.size(); i++)
         if (lru_q[i] == way) begin
            lru_q.delete(i);
            break;
         end
      lru_q.push_front(way);
   endtask

   task automatic model_op(input bit c, input bit wr, input int wd,
                           input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                           input bit vi);
      int hw = -1;
      int vic = -1;
      int way;
      bit h;
      for (int i = 0; i < WAYS; i++)
         if (hw < 0 && m_valid[i] && m_tag[i] == t) hw = i;
      for (int i = 0; i < WAYS; i++)
         if (vic < 0 && !m_valid[i]) vic = i;
      if (vic < 0) vic = lru_q[lru_q.size() - 1];
      h = c && (hw >= 0);
      way = h ? hw : vic;
      if (h && wr) begin
         m_data[way][wd] = d;
         m_dk[way][wd]   = 1;
         m_dirty[way]    = 1;
      end
      if (!c && wr) begin
         m_data[way][wd] = d;
         m_dk[way][wd]   = 1;
         m_tag[way]      = t;
         m_tk[way]       = 1;
         m_valid[way]    = vi;
         m_dirty[way]    = 0;
      end
      if (h || (!c && wr)) touch(way);
      exp_q.push_back({m_dk[way][wd], m_tk[way], h, m_dirty[way], m_valid[way],
                       m_tag[way], m_data[way][wd]});
      ack_due = 1;
   endtask

   // Compare process: ack and every output checked on each falling edge.
   always @(negedge clk) begin
      if (ack) ack_cnt++;
      if (chk_en) begin
         logic e_ack;
         e_ack = 1'b0;
         if (ack_due) begin
            ack_due = 0;
            e_ack = 1'b1;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL exp_q: empty at %0t", $time);
            end else cur = exp_q.pop_front();
         end
         check("ack", ack, e_ack);
         check("hit", hit, cur[DATA_W+TAG_W+2]);
         check("dirty", dirty, cur[DATA_W+TAG_W+1]);
         check("valid", valid, cur[DATA_W+TAG_W]);
         if (cur[DATA_W+TAG_W+3]) check("tag_out", tag_out, cur[DATA_W +: TAG_W]);
         if (cur[DATA_W+TAG_W+4]) check("data_out", data_out, cur[DATA_W-1:0]);
      end
   end

   // Returns on the falling edge during which the ack of this request is high.
   task automatic do_req(input bit c, input bit wr, input int wd,
                         input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                         input bit vi);
      @(negedge clk);
      cmp = c; write = wr; word = wd[WB-1:0]; tag = t; data_in = d; valid_in = vi;
      enable = 1'b1;
      @(posedge clk);
      model_op(c, wr, wd, t, d, vi);
      #1 enable = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bit busy;
      int a0;
      for (int w = 0; w < WAYS; w++) begin
         m_tk[w] = 0;
         for (int k = 0; k < WORDS; k++) m_dk[w][k] = 0;
      end
      model_reset();
      #12;
      check("rst_hit", hit, 0);
      check("rst_dirty", dirty, 0);
      check("rst_valid", valid, 0);
      check("rst_ack", ack, 0);
      check("rst_tag_out", tag_out, 0);
      check("rst_data_out", data_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1;

      // Cold compare-read
      do_req(1, 0, 3, 5'b11101, 16'h0000, 0);
      check("t1_ack", ack, 1);
      check("t1_hit", hit, 0);
      check("t1_valid", valid, 0);
      check("t1_dirty", dirty, 0);

      // Fill way0, then hit it
      do_req(0, 1, 3, 5'b11101, 16'h0F0F, 1);
      do_req(1, 0, 3, 5'b11101, 16'h0000, 0);
      check("t2_hit", hit, 1);
      check("t2_data", data_out, 16'h0F0F);
      check("t2_tag", tag_out, 5'b11101);
      check("t2_valid", valid, 1);
      check("t2_dirty", dirty, 0);

      // Compare-write hit marks the line dirty
      do_req(1, 1, 3, 5'b11101, 16'hA5A5, 0);
      do_req(1, 0, 3, 5'b11101, 16'h0000, 0);
      check("t3_hit", hit, 1);
      check("t3_data", data_out, 16'hA5A5);
      check("t3_dirty", dirty, 1);

      // LRU ordering
      do_req(0, 1, 0, 5'h03, 16'h1111, 1);
      do_req(1, 0, 3, 5'h1D, 16'h0000, 0);
      do_req(0, 0, 0, 5'h00, 16'h0000, 0);
      check("t4_victim_tag", tag_out, 5'h03);
      check("t4_victim_hit", hit, 0);
      do_req(0, 1, 0, 5'h07, 16'h2222, 1);
      do_req(1, 0, 0, 5'h03, 16'h0000, 0);
      check("t4_evicted", hit, 0);
      do_req(1, 0, 3, 5'h1D, 16'h0000, 0);
      check("t4_kept", hit, 1);

      // Miss onto a dirty victim reports it for writeback
      do_req(1, 1, 0, 5'h07, 16'h3333, 0);
      do_req(1, 0, 3, 5'h0A, 16'h0000, 0);
      check("t5_hit", hit, 0);
      check("t5_dirty", dirty, 1);
      check("t5_valid", valid, 1);
      check("t5_tag", tag_out, 5'h1D);
      check("t5_data", data_out, 16'hA5A5);
      do_req(1, 0, 3, 5'h1D, 16'h0000, 0);
      check("t5_unchanged", data_out, 16'hA5A5);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         do_req($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, WORDS - 1),
                TAG_W'($urandom_range(0, 5)), DATA_W'($urandom),
                $urandom_range(0, 7) != 0);
      end

      // enable held high: one request accepted every two cycles
      @(negedge clk);
      cmp = 0; write = 0; word = 1; tag = '0; data_in = '0; valid_in = 0;
      enable = 1'b1;
      busy = 0;
      a0 = ack_cnt;
      repeat (10) begin
         @(posedge clk);
         if (!busy) begin
            model_op(0, 0, 1, '0, '0, 0);
            busy = 1;
         end else busy = 0;
      end
      #1 enable = 1'b0;
      @(negedge clk);
      check("t6_ack_count", ack_cnt - a0, 5);

      // Asynchronous reset while in RESP
      @(negedge clk);
      cmp = 0; write = 0; word = 2; enable = 1'b1;
      @(posedge clk);
      #1 enable = 1'b0;
      chk_en = 0;
      #1 rst_n = 1'b0;
      #1 check("t6_ack_drop", ack, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1;
      do_req(1, 0, 3, 5'h1D, 16'h0000, 0);
      check("t6_rst_hit", hit, 0);
      check("t6_rst_valid", valid, 0);
      do_req(0, 0, 0, 5'h00, 16'h0000, 0);
      check("t6_rst_valid_acc", valid, 0);
      check("t6_rst_dirty_acc", dirty, 0);

      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/assoc_set.md
Name: assoc_set

Overview:
- Parametrised N-way set-associative cache set: successor to the single-line set.
- Holds WAYS lines of WORDS words each, with per-way tag, valid and dirty state and true-LRU replacement.
- Registered request/ack handshake: each request gets exactly one ack pulse.
- Sits between the cache controller, which issues compare and access operations, and the backing-memory refill/writeback path.

Parameters:
- WAYS, 2, associativity; power of two, minimum 2.
- WORDS, 4, words per line; power of two, minimum 2.
- DATA_W, 16, bits per word.
- TAG_W, 5, tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  request strobe; sampled only in IDLE.
- cmp  input  1  1 = compare mode (tag lookup); 0 = access mode (operate on the victim way).
- write  input  1  1 = write operation; 0 = read operation.
- word  input  log2(WORDS)  word select within the line.
- tag  input  TAG_W  request tag.
- data_in  input  DATA_W  write data.
- valid_in  input  1  valid bit stored on an access-write (fill).
- hit  output  1  compare hit: tag matched on a valid way.
- dirty  output  1  dirty bit of the reported way.
- tag_out  output  TAG_W  tag of the reported way.
- data_out  output  DATA_W  word read from the reported way.
- valid  output  1  valid bit of the reported way.
- ack  output  1  one-cycle pulse; all outputs are valid during it.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous):
  - all valid and dirty bits cleared; way i age = i;
  - hit, dirty, valid, ack = 0; tag_out, data_out = 0;
  - FSM = IDLE; tag and data arrays are not reset.
- FSM has two states, IDLE and RESP.
  - IDLE: enable=1 at a clock edge captures cmp, write, word, tag, data_in and valid_in, performs the operation, registers the outputs and moves to RESP.
  - RESP: ack=1 for exactly one cycle, then IDLE. enable is ignored in RESP.
  - Maximum request rate is one every 2 cycles.
  - Outputs hold their values after ack until the next request completes.
- Reported way:
  - compare hit: the matching way;
  - compare miss, or any access op: the victim way.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way with age = WAYS-1.
- Operations (hit=0 for every access-mode op):
  - Compare-read (cmp=1, write=0): hit = any valid way whose tag matches. On hit, data_out = that way's word. On miss, data_out, tag_out, dirty and valid come from the victim, for writeback decision.
  - Compare-write (cmp=1, write=1): on hit, write data_in into the word, set dirty=1, and outputs reflect the post-write state. On miss, no array change and outputs report the victim.
  - Access-read (cmp=0, write=0): read the victim's word, tag, dirty and valid. LRU is not updated, so a following fill targets the same way.
  - Access-write (cmp=0, write=1): fill. Write data_in into the victim word, tag := tag, valid := valid_in, dirty := 0. Outputs reflect the post-write state.
- LRU update on a compare hit (read or write) and on every access-write:
  - accessed way age := 0;
  - every way with age less than the accessed way's old age increments by 1;
  - ages always form a permutation of 0..WAYS-1.
- No LRU change on a miss or an access-read.
- Duplicate valid tags cannot occur under correct controller use. If they do, the lowest-index match wins.
- rst_n asserted mid-request (in RESP): ack drops immediately, the in-flight write may be lost, and the FSM returns to IDLE.

Test Plan:
1. Reset, then compare-read tag=5'b11101 word=3 -> ack one cycle after the enable edge; hit=0, valid=0, dirty=0.
2. Fill way0: cmp=0, write=1, valid_in=1, tag=5'b11101, word=3, data_in=16'h0F0F; then compare-read the same tag and word -> hit=1, data_out=16'h0F0F, tag_out=5'b11101, valid=1, dirty=0.
3. Compare-write tag=5'b11101 word=3 data_in=16'hA5A5, then compare-read it -> hit=1, data_out=16'hA5A5, dirty=1.
4. LRU, WAYS=2:
   - fill tag 5'h1D into way0 and tag 5'h03 into way1, then compare-hit 5'h1D;
   - access-read -> tag_out=5'h03 (way1 is the victim);
   - fill tag 5'h07, then compare 5'h03 -> hit=0; compare 5'h1D -> hit=1.
5. Compare miss with all ways valid and the victim dirty -> hit=0, dirty=1, valid=1, tag_out = victim tag; arrays unchanged.
6. Hold enable=1 continuously for 10 cycles -> exactly 5 ack pulses. Assert rst_n=0 during RESP -> ack goes to 0 within the same cycle, and all valid bits read back as 0.
